demux18_scan: RTL

- 1-to-8 demultiplexer / deserializer. It is the receive end of the time-division link driven by the 8-to-1 MUX81 path.
- Takes one sample per handshake and routes it to one of LANES registered outputs.
- Addressed mode: lane is chosen by S. Scan mode: an internal pointer walks lanes 0..LANES-1 and presents a completed frame with a valid/ready handshake.

---
 rtl/demux18_pkg.sv | 26 ++
 rtl/demux18_lane_reg.sv | 26 ++
 rtl/demux18_scan.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/demux18_pkg.sv
// Shared types and constants for the demux18 scan deserializer.
// Holds the controller state encoding, the default geometry and the lane-select decoder.
package demux18_pkg;

    localparam int DEF_LANES = 8;
    localparam int DEF_WIDTH = 1;
    localparam int MAX_LANES = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        SCAN = 2'd2,
        FULL = 2'd3
    } state_t;

    // Selects at or beyond n decode to an all-zero mask, so an out-of-range lane is never written.
    function automatic logic [MAX_LANES-1:0] onehot(input int unsigned sel, input int unsigned n);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < MAX_LANES; k++) begin
            m[k] = (sel == k) && (sel < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/demux18_lane_reg.sv
// One output lane: holds the last sample written to it and pulses strobe on the cycle after a write.
// Latency: one cycle from write enable to q and strobe. No backpressure; writes are always taken.
module demux18_lane_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             strobe
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= we;
            if (we) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/demux18_scan.sv
// 1-to-LANES demux: addressed writes by S, or a scan pointer that builds a frame offered on out_valid/out_ready.
// One-cycle latency to Q/lane_strobe; in_ready drops while a frame waits. DEMUX18_PARITY_EN adds a parity sample and parity_err.
module demux18_scan
    import demux18_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = $clog2(LANES)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   ENb,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       S,
    input  logic [WIDTH-1:0]       D,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LANES*WIDTH-1:0] Q,
    output logic [LANES-1:0]       lane_strobe,
    output logic [SEL_W-1:0]       lane_ptr,
    output logic                   out_valid,
`ifdef DEMUX18_PARITY_EN
    output logic                   parity_err,
`endif
    input  logic                   out_ready
);

    state_t            r_state;
    state_t            w_next;
    logic [SEL_W-1:0]  r_ptr;
    logic [LANES-1:0]  w_we;
    logic              w_go_addr;
    logic              w_go_scan;
    logic              w_ptr_last;
    logic              w_scan_acc;
    logic              w_frame_end;
    logic              w_par_wait;

    assign w_go_addr  = !ENb && !mode;
    assign w_go_scan  = !ENb && mode;
    assign w_ptr_last = (r_ptr == SEL_W'(LANES - 1));
    assign w_scan_acc = (r_state == SCAN) && w_go_scan && in_valid;

`ifdef DEMUX18_PARITY_EN
    logic r_par_wait;
    logic r_par_err;

    assign w_par_wait  = r_par_wait;
    assign w_frame_end = w_scan_acc && r_par_wait;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_par_wait <= 1'b0;
        end else if ((r_state != SCAN) || !w_go_scan) begin
            r_par_wait <= 1'b0;
        end else if (w_scan_acc) begin
            r_par_wait <= !r_par_wait && w_ptr_last;
        end
    end

    // The last lane landed on the previous edge, so Q already holds the complete frame here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_par_err <= 1'b0;
        end else if (w_frame_end) begin
            r_par_err <= D[0] ^ (^Q);
        end else if ((r_state == FULL) && out_ready) begin
            r_par_err <= 1'b0;
        end
    end

    assign parity_err = r_par_err;
`else
    assign w_par_wait  = 1'b0;
    assign w_frame_end = w_scan_acc && w_ptr_last;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_go_addr) begin
                    w_next = ADDR;
                end else if (w_go_scan) begin
                    w_next = SCAN;
                end
            end
            ADDR: begin
                if (!w_go_addr) begin
                    w_next = IDLE;
                end
            end
            SCAN: begin
                if (!w_go_scan) begin
                    w_next = IDLE;
                end else if (w_frame_end) begin
                    w_next = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    w_next = w_go_scan ? SCAN : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // in_ready follows ENb/mode so a cycle that leaves ADDR or SCAN never completes a handshake.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_we      = '0;
        case (r_state)
            ADDR: begin
                in_ready = w_go_addr;
                if (in_valid && w_go_addr) begin
                    w_we = LANES'(onehot(32'(S), LANES));
                end
            end
            SCAN: begin
                in_ready = w_go_scan;
                if (w_scan_acc && !w_par_wait) begin
                    w_we = LANES'(onehot(32'(r_ptr), LANES));
                end
            end
            FULL: begin
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if ((r_state != SCAN) || !w_go_scan) begin
            r_ptr <= '0;
        end else if (w_scan_acc && !w_par_wait) begin
`ifdef DEMUX18_PARITY_EN
            r_ptr <= w_ptr_last ? r_ptr : r_ptr + 1'b1;
`else
            r_ptr <= w_ptr_last ? '0 : r_ptr + 1'b1;
`endif
        end else if (w_frame_end) begin
            r_ptr <= '0;
        end
    end

    assign lane_ptr = r_ptr;

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            demux18_lane_reg #(.WIDTH(WIDTH)) u_lane (
                .clk    (clock),
                .rst_n  (reset_n),
                .we     (w_we[k]),
                .d      (D),
                .q      (Q[k*WIDTH +: WIDTH]),
                .strobe (lane_strobe[k])
            );
        end
    endgenerate

endmodule
